// File: rtl/shift_pkg.sv
// Shared definitions for the 16-bit shift pipeline: operation encoding and widths.
package shift_pkg;

  localparam int DATA_W = 16;
  localparam int AMT_W  = 4;

  typedef enum logic [1:0] {
    OP_LSR = 2'b00,
    OP_LSL = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_e;

endpackage

// File: rtl/shift_core_16bit.sv
// Combinational 16-bit shifter: four mux levels (8, 4, 2, 1) with op-selected fill,
// plus the "last bit shifted out" carry.
// Build option: SHIFT_PIPE_ROTATE_EN enables ROR; without it op 11 behaves as LSR
// and no rotate path exists.
module shift_core_16bit
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  input  op_e               op,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  // One mux level: shift by n when en is set; returns {carry, value}.
  // The carry of the last enabled level is the overall last bit shifted out,
  // since each level sees the value already shifted by the earlier levels.
  function automatic logic [DATA_W:0] shift_level(
    input logic [DATA_W-1:0] v,
    input logic              c_in,
    input logic              en,
    input op_e               lop,
    input logic [4:0]        n
  );
    logic [DATA_W-1:0] r_s;
    logic [DATA_W-1:0] t_s;
    logic              c_s;
    r_s = v;
    t_s = {DATA_W{1'b0}};
    c_s = c_in;
    if (en) begin
      case (lop)
        OP_LSL: begin
          t_s = v << (n - 5'd1);
          c_s = t_s[DATA_W-1];
          r_s = v << n;
        end
        OP_ASR: begin
          t_s = v >> (n - 5'd1);
          c_s = t_s[0];
          r_s = (v >> n) | ((~({DATA_W{1'b1}} >> n)) & {DATA_W{v[DATA_W-1]}});
        end
`ifdef SHIFT_PIPE_ROTATE_EN
        OP_ROR: begin
          t_s = v >> (n - 5'd1);
          c_s = t_s[0];
          r_s = (v >> n) | (v << (5'd16 - n));
        end
`endif
        default: begin
          // LSR, and op 11 when rotate is not built in
          t_s = v >> (n - 5'd1);
          c_s = t_s[0];
          r_s = v >> n;
        end
      endcase
    end else begin
      r_s = v;
      c_s = c_in;
    end
    return {c_s, r_s};
  endfunction

  logic [DATA_W:0] l8_s;
  logic [DATA_W:0] l4_s;
  logic [DATA_W:0] l2_s;
  logic [DATA_W:0] l1_s;

  // Chain the four levels; carry starts at 0 so amt=0 yields carry 0.
  always_comb begin
    l8_s   = shift_level(data,               1'b0,         amt[3], op, 5'd8);
    l4_s   = shift_level(l8_s[DATA_W-1:0],   l8_s[DATA_W], amt[2], op, 5'd4);
    l2_s   = shift_level(l4_s[DATA_W-1:0],   l4_s[DATA_W], amt[1], op, 5'd2);
    l1_s   = shift_level(l2_s[DATA_W-1:0],   l2_s[DATA_W], amt[0], op, 5'd1);
    result = l1_s[DATA_W-1:0];
    carry  = l1_s[DATA_W];
  end

endmodule

// File: rtl/shift_pipe_16bit.sv
// Two-stage valid/ready shift pipeline. S1 holds operands, S2 holds the result
// and flags; the shifter sits between them.
// Build option: SHIFT_PIPE_ROTATE_EN (see shift_core_16bit) enables ROR on op 11.
module shift_pipe_16bit
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_data_r;
  logic [3:0]       s1_amt_r;
  op_e              s1_op_r;

  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_data_r;
  logic             s2_carry_r;
  logic             s2_zero_r;

  logic             s1_adv_s;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic [WIDTH-1:0] core_result_s;
  logic             core_carry_s;

  // Handshake control: S1 moves on when S2 is empty or draining this cycle.
  always_comb begin
    out_xfer_s = s2_valid_r && out_ready;
    s1_adv_s   = s1_valid_r && (!s2_valid_r || out_ready);
    in_ready   = !s1_valid_r || s1_adv_s;
    in_xfer_s  = in_valid && in_ready;
  end

  shift_core_16bit u_core (
    .data   (s1_data_r),
    .amt    (s1_amt_r),
    .op     (s1_op_r),
    .result (core_result_s),
    .carry  (core_carry_s)
  );

  // Stage 1: capture operands on transfer in, otherwise hold or empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {WIDTH{1'b0}};
      s1_amt_r   <= 4'd0;
      s1_op_r    <= OP_LSR;
    end else if (in_xfer_s) begin
      s1_valid_r <= 1'b1;
      s1_data_r  <= in_data;
      s1_amt_r   <= in_amt;
      s1_op_r    <= op_e'(in_op);
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: register result and flags together; hold them while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= {WIDTH{1'b0}};
      s2_carry_r <= 1'b0;
      s2_zero_r  <= 1'b0;
    end else if (s1_adv_s) begin
      s2_valid_r <= 1'b1;
      s2_data_r  <= core_result_s;
      s2_carry_r <= core_carry_s;
      s2_zero_r  <= (core_result_s == {WIDTH{1'b0}});
    end else if (out_xfer_s) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  assign out_valid = s2_valid_r;
  assign out_data  = s2_data_r;
  assign out_carry = s2_carry_r;
  assign out_zero  = s2_zero_r;

endmodule
